// File: rtl/fighter_ctrl_if.sv
// Player-side bus between the button/opponent inputs, the hit resolver and one fighter_ctrl.
// The slave modport is the controller; the master modport is whoever drives the frame inputs.
interface fighter_ctrl_if #(
  parameter int POS_WIDTH = 10
);
  logic                 SCEN;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_attack;
  logic [POS_WIDTH-1:0] opp_x;
  logic                 hit_event;
  logic                 hitstun_active;
  logic signed [7:0]    kb_dx;
  logic signed [7:0]    kb_dy;
  logic                 opp_hit_event;
  logic [POS_WIDTH-1:0] pos_x;
  logic [POS_WIDTH-1:0] pos_y;
  logic                 face_right;
  logic                 attack_damage;
  logic [2:0]           state;

  modport slave (
    input  SCEN, btn_left, btn_right, btn_attack, opp_x,
           hit_event, hitstun_active, kb_dx, kb_dy, opp_hit_event,
    output pos_x, pos_y, face_right, attack_damage, state
  );

  modport master (
    output SCEN, btn_left, btn_right, btn_attack, opp_x,
           hit_event, hitstun_active, kb_dx, kb_dy, opp_hit_event,
    input  pos_x, pos_y, face_right, attack_damage, state
  );
endinterface

// File: rtl/fighter_ctrl.sv
// Per-player fighter FSM (walk, three-phase attack, hitstun knockback); advances only on SCEN,
// every output registered and visible one clk after the SCEN cycle.
module fighter_ctrl #(
  parameter int POS_WIDTH  = 10,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 623,
  parameter int GROUND_Y   = 400,
  parameter int INIT_X     = 100,
  parameter int FACE_INIT  = 1,
  parameter int WALK_SPEED = 2,
  parameter int GRAVITY    = 1,
  parameter int STARTUP    = 4,
  parameter int ACTIVE     = 3,
  parameter int RECOVERY   = 8
) (
  input  logic          clk,
  input  logic          reset,
  fighter_ctrl_if.slave bus
);

  localparam int PW = POS_WIDTH;
  localparam int EW = POS_WIDTH + 2;

  localparam logic signed [EW-1:0] XMIN_S = EW'(X_MIN);
  localparam logic signed [EW-1:0] XMAX_S = EW'(X_MAX);
  localparam logic signed [EW-1:0] YGND_S = EW'(GROUND_Y);
  localparam logic signed [EW-1:0] WS_S   = EW'(WALK_SPEED);
  localparam logic signed [7:0]    GRAV_S = 8'(GRAVITY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WALK     = 3'd1,
    S_STARTUP  = 3'd2,
    S_ACTIVE   = 3'd3,
    S_RECOVERY = 3'd4,
    S_HITSTUN  = 3'd5
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     pos_x_q;
  logic [PW-1:0]     pos_y_q;
  logic              face_right_q;
  logic              attack_damage_q;
  logic signed [7:0] vx_q;
  logic signed [7:0] vy_q;
  logic [7:0]        cnt_q;
  logic              atk_prev_q;

  logic signed [EW-1:0] x_s, y_s, vx_s, vy_s;
  logic signed [EW-1:0] x_sum, y_sum, walk_sum;
  logic [PW-1:0]        hs_x_d, hs_y_d, walk_x_d;
  logic signed [7:0]    hs_vx_d, hs_vy_d;
  logic                 atk_press;
  logic                 walk_one;

  assign x_s       = $signed({2'b00, pos_x_q});
  assign y_s       = $signed({2'b00, pos_y_q});
  assign vx_s      = EW'(vx_q);
  assign vy_s      = EW'(vy_q);
  assign atk_press = bus.btn_attack & ~atk_prev_q;
  assign walk_one  = bus.btn_left ^ bus.btn_right;

  // Hitstun physics: move by the current velocity, then decay vx / apply gravity to vy.
  always_comb begin
    x_sum   = x_s + vx_s;
    hs_vx_d = vx_q;
    if (vx_q > 8'sd0) begin
      hs_vx_d = vx_q - 8'sd1;
    end else if (vx_q < 8'sd0) begin
      hs_vx_d = vx_q + 8'sd1;
    end
    hs_x_d = x_sum[PW-1:0];
    if (x_sum < XMIN_S) begin
      hs_x_d  = PW'(X_MIN);
      hs_vx_d = '0;
    end else if (x_sum > XMAX_S) begin
      hs_x_d  = PW'(X_MAX);
      hs_vx_d = '0;
    end

    y_sum   = y_s + vy_s;
    hs_vy_d = vy_q + GRAV_S;
    hs_y_d  = y_sum[PW-1:0];
    if (y_sum >= YGND_S) begin
      hs_y_d  = PW'(GROUND_Y);
      hs_vy_d = '0;
    end else if (y_sum[EW-1]) begin
      hs_y_d = '0;
    end

    walk_sum = bus.btn_left ? (x_s - WS_S) : (x_s + WS_S);
    walk_x_d = walk_sum[PW-1:0];
    if (walk_sum < XMIN_S) begin
      walk_x_d = PW'(X_MIN);
    end else if (walk_sum > XMAX_S) begin
      walk_x_d = PW'(X_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pos_x_q         <= PW'(INIT_X);
      pos_y_q         <= PW'(GROUND_Y);
      face_right_q    <= FACE_INIT[0];
      attack_damage_q <= 1'b0;
      vx_q            <= '0;
      vy_q            <= '0;
      cnt_q           <= '0;
      atk_prev_q      <= 1'b0;
    end else if (bus.SCEN) begin
      atk_prev_q <= bus.btn_attack;
      if (state_q == S_IDLE || state_q == S_WALK) begin
        face_right_q <= (bus.opp_x >= pos_x_q);
      end

      if (bus.hit_event) begin
        state_q         <= S_HITSTUN;
        vx_q            <= bus.kb_dx;
        vy_q            <= bus.kb_dy;
        attack_damage_q <= 1'b0;
        cnt_q           <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_WALK: begin
            if (atk_press) begin
              state_q <= S_STARTUP;
              cnt_q   <= 8'(STARTUP - 1);
            end else if (walk_one) begin
              state_q <= S_WALK;
              pos_x_q <= walk_x_d;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_STARTUP: begin
            if (cnt_q == 8'd0) begin
              state_q         <= S_ACTIVE;
              cnt_q           <= 8'(ACTIVE - 1);
              attack_damage_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_ACTIVE: begin
            // A landed hit kills the hitbox for the rest of the swing without shortening it.
            if (bus.opp_hit_event) begin
              attack_damage_q <= 1'b0;
            end
            if (cnt_q == 8'd0) begin
              state_q         <= S_RECOVERY;
              cnt_q           <= 8'(RECOVERY - 1);
              attack_damage_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_RECOVERY: begin
            if (cnt_q == 8'd0) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_HITSTUN: begin
            if (!bus.hitstun_active && pos_y_q == PW'(GROUND_Y)) begin
              state_q <= S_IDLE;
              vx_q    <= '0;
              vy_q    <= '0;
            end else begin
              pos_x_q <= hs_x_d;
              pos_y_q <= hs_y_d;
              vx_q    <= hs_vx_d;
              vy_q    <= hs_vy_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pos_x         = pos_x_q;
  assign bus.pos_y         = pos_y_q;
  assign bus.face_right    = face_right_q;
  assign bus.attack_damage = attack_damage_q;
  assign bus.state         = state_q;

endmodule
